// File: rtl/regfile_mwp_sb.sv
// regfile_mwp_sb -- scalar integer register file with N write ports,
// M read ports, same-cycle write-to-read bypass and a per-register busy
// scoreboard.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   write_En/Addr/Data  per-port writeback; higher port index wins on a clash
//   alloc_En/Addr       mark a register busy (new in-flight producer)
//   flush               clear every busy bit
//   read_Addr           per-port read address
//   data_Out            per-port read data, bypassed from same-cycle writes
//   read_Ready          per-port operand-available flag
//   busy_Vec            registered busy bits
//
// Register 0 and addresses >= SIZE read as zero, are always ready and
// ignore writes and allocations.
module regfile_mwp_sb #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int SIZE        = 64,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [WRITE_PORTS-1:0]                  write_En,
  input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]  write_Addr,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  write_Data,
  input  logic                                    alloc_En,
  input  logic [ADDR_WIDTH-1:0]                   alloc_Addr,
  input  logic                                    flush,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]   read_Addr,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]   data_Out,
  output logic [READ_PORTS-1:0]                   read_Ready,
  output logic [SIZE-1:0]                         busy_Vec
);

  // One extra bit so SIZE == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(SIZE);

  // True for addresses that name a real, writable register.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && ({1'b0, a} < LIMIT);
  endfunction

  logic [DATA_WIDTH-1:0]  regs_q [SIZE];
  logic [SIZE-1:0]        busy_q;
  logic [SIZE-1:0]        busy_d;
  logic [WRITE_PORTS-1:0] wr_ok;
  logic [SIZE-1:0]        wr_hit;
  logic                   alloc_ok;

  always_comb begin
    for (int p = 0; p < WRITE_PORTS; p++) begin
      wr_ok[p] = write_En[p] && addr_ok(write_Addr[p]);
    end
  end

  assign alloc_ok = alloc_En && addr_ok(alloc_Addr);

  // Which registers receive a writeback this cycle (any port).
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < SIZE; r++) begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (wr_ok[p] && (write_Addr[p] == ADDR_WIDTH'(r))) begin
          wr_hit[r] = 1'b1;
        end
      end
    end
  end

  // Storage: register 0 is never written because wr_ok excludes address 0,
  // so it stays at its reset value of zero.
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] reg_d;

      // Ascending scan: the last matching (highest-index) port wins.
      always_comb begin
        reg_d = regs_q[gi];
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (wr_ok[p] && (write_Addr[p] == ADDR_WIDTH'(gi))) begin
            reg_d = write_Data[p];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_q[gi] <= '0;
        end else begin
          regs_q[gi] <= reg_d;
        end
      end
    end
  endgenerate

  // Scoreboard: flush beats alloc, alloc beats a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < SIZE; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (alloc_ok && (alloc_Addr == ADDR_WIDTH'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_Vec = busy_q;

  // Read ports. Outputs are forced to the reset view while rst_n is low so
  // a write presented during reset cannot leak through the bypass.
  generate
    for (gi = 0; gi < READ_PORTS; gi++) begin : g_rd
      logic [DATA_WIDTH-1:0] rd_data;
      logic                  rd_rdy;
      logic                  rd_byp;

      always_comb begin
        rd_data = '0;
        rd_rdy  = 1'b1;
        rd_byp  = 1'b0;
        if (rst_n && addr_ok(read_Addr[gi])) begin
          rd_data = regs_q[read_Addr[gi]];
          for (int p = 0; p < WRITE_PORTS; p++) begin
            if (wr_ok[p] && (write_Addr[p] == read_Addr[gi])) begin
              rd_data = write_Data[p];
              rd_byp  = 1'b1;
            end
          end
          // A producer writing back this cycle makes the operand available.
          rd_rdy = !busy_q[read_Addr[gi]] || rd_byp;
        end
      end

      assign data_Out[gi]   = rd_data;
      assign read_Ready[gi] = rd_rdy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mwp_sb.sv
module tb_regfile_mwp_sb;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int SZ = 48;   // below 2**AW so out-of-range addresses exist
  localparam int RP = 2;
  localparam int WP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [WP-1:0]         write_En;
  logic [WP-1:0][AW-1:0] write_Addr;
  logic [WP-1:0][DW-1:0] write_Data;
  logic                  alloc_En;
  logic [AW-1:0]         alloc_Addr;
  logic                  flush;
  logic [RP-1:0][AW-1:0] read_Addr;
  logic [RP-1:0][DW-1:0] data_Out;
  logic [RP-1:0]         read_Ready;
  logic [SZ-1:0]         busy_Vec;

  always #5 clk = ~clk;

  regfile_mwp_sb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ),
    .READ_PORTS(RP), .WRITE_PORTS(WP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .write_En(write_En), .write_Addr(write_Addr), .write_Data(write_Data),
    .alloc_En(alloc_En), .alloc_Addr(alloc_Addr), .flush(flush),
    .read_Addr(read_Addr), .data_Out(data_Out),
    .read_Ready(read_Ready), .busy_Vec(busy_Vec)
  );

  typedef struct packed {
    int                    id;
    logic [RP-1:0][AW-1:0] ra;
    logic [RP-1:0][DW-1:0] data;
    logic [RP-1:0]         rdy;
    logic [SZ-1:0]         busy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;
  int txn = 0;

  // Reference model: architectural register contents and busy flags.
  logic [DW-1:0] mem [SZ];
  bit            mbusy [SZ];

  function automatic bit in_rng(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < SZ);
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < SZ; r++) begin
      mem[r] = '0;
      mbusy[r] = 1'b0;
    end
  endfunction

  // Expected outputs for the inputs currently applied.
  function automatic exp_t predict();
    exp_t e;
    e.id = txn;
    e.ra = read_Addr;
    for (int r = 0; r < SZ; r++) e.busy[r] = mbusy[r];
    for (int i = 0; i < RP; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit hit;
      a = read_Addr[i];
      e.data[i] = '0;
      e.rdy[i] = 1'b1;
      if (rst_n && in_rng(a)) begin
        d = mem[int'(a)];
        hit = 1'b0;
        for (int p = 0; p < WP; p++) begin
          if (write_En[p] && write_Addr[p] == a) begin
            d = write_Data[p];
            hit = 1'b1;
          end
        end
        e.data[i] = d;
        e.rdy[i] = !mbusy[int'(a)] || hit;
      end
    end
    return e;
  endfunction

  // State update at a rising edge, using the inputs applied during the cycle.
  function automatic void model_clock();
    bit nb [SZ];
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int r = 0; r < SZ; r++) begin
      bit written;
      written = 1'b0;
      for (int p = 0; p < WP; p++) begin
        if (write_En[p] && int'(write_Addr[p]) == r) written = 1'b1;
      end
      if (r == 0) nb[r] = 1'b0;
      else if (flush) nb[r] = 1'b0;
      else if (alloc_En && int'(alloc_Addr) == r) nb[r] = 1'b1;
      else if (written) nb[r] = 1'b0;
      else nb[r] = mbusy[r];
    end
    for (int r = 0; r < SZ; r++) mbusy[r] = nb[r];
    for (int p = 0; p < WP; p++) begin
      if (write_En[p] && in_rng(write_Addr[p])) mem[int'(write_Addr[p])] = write_Data[p];
    end
  endfunction

  task automatic idle();
    write_En = '0;
    write_Addr = '0;
    write_Data = '0;
    alloc_En = 1'b0;
    alloc_Addr = '0;
    flush = 1'b0;
    read_Addr = '0;
  endtask

  // Inputs are already applied (at posedge+1); record the expectation,
  // let the cycle run, then return to idle inputs.
  task automatic issue();
    if (!rst_n) model_clear();
    q.push_back(predict());
    txn++;
    @(posedge clk);
    model_clock();
    #1;
    idle();
  endtask

  task automatic check(input string nm, input int id, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s txn=%0d actual=%h required=%h", nm, id, act, req);
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle with the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      $display("txn %0d ra0=%0d ra1=%0d d0=%h d1=%h rdy=%b busy=%h",
               e.id, e.ra[0], e.ra[1], data_Out[0], data_Out[1], read_Ready, busy_Vec);
      check("data0", e.id, 64'(data_Out[0]), 64'(e.data[0]));
      check("data1", e.id, 64'(data_Out[1]), 64'(e.data[1]));
      check("ready", e.id, 64'(read_Ready), 64'(e.rdy));
      check("busy",  e.id, 64'(busy_Vec),   64'(e.busy));
    end
  end

  initial begin
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Post-reset reads of x5 and x0
    read_Addr[0] = 6'd5; read_Addr[1] = 6'd0; issue();
    read_Addr[0] = 6'd0; read_Addr[1] = 6'd5; issue();

    // Single write with bypass, then stored read
    write_En[0] = 1'b1; write_Addr[0] = 6'd3; write_Data[0] = 32'hDEAD_BEEF;
    read_Addr[0] = 6'd3; read_Addr[1] = 6'd3; issue();
    read_Addr[0] = 6'd3; issue();

    // Same-address clash: port 1 wins; write to x0 ignored
    write_En = 2'b11; write_Addr[0] = 6'd7; write_Addr[1] = 6'd7;
    write_Data[0] = 32'h11; write_Data[1] = 32'h22;
    read_Addr[0] = 6'd7; issue();
    read_Addr[1] = 6'd7; issue();
    write_En[0] = 1'b1; write_Addr[0] = 6'd0; write_Data[0] = 32'h55;
    read_Addr[0] = 6'd0; issue();
    read_Addr[1] = 6'd0; issue();

    // Allocate x9, then write it back
    alloc_En = 1'b1; alloc_Addr = 6'd9; read_Addr[0] = 6'd9; issue();
    read_Addr[0] = 6'd9; issue();
    write_En[1] = 1'b1; write_Addr[1] = 6'd9; write_Data[1] = 32'h1234;
    read_Addr[0] = 6'd9; issue();
    read_Addr[1] = 6'd9; issue();

    // Alloc beats writeback; flush beats alloc
    alloc_En = 1'b1; alloc_Addr = 6'd4;
    write_En[0] = 1'b1; write_Addr[0] = 6'd4; write_Data[0] = 32'hAB;
    read_Addr[0] = 6'd4; issue();
    read_Addr[0] = 6'd4; issue();
    alloc_En = 1'b1; alloc_Addr = 6'd4; flush = 1'b1; issue();
    read_Addr[0] = 6'd4; issue();

    // Several allocations then a flush; data unaffected
    alloc_En = 1'b1; alloc_Addr = 6'd1; issue();
    alloc_En = 1'b1; alloc_Addr = 6'd2; issue();
    alloc_En = 1'b1; alloc_Addr = 6'd10; read_Addr[0] = 6'd1; issue();
    flush = 1'b1; read_Addr[0] = 6'd3; read_Addr[1] = 6'd7; issue();
    read_Addr[0] = 6'd1; read_Addr[1] = 6'd2; issue();

    // Out-of-range address and alloc of x0 are ignored
    write_En[1] = 1'b1; write_Addr[1] = 6'd50; write_Data[1] = 32'h77;
    alloc_En = 1'b1; alloc_Addr = 6'd50;
    read_Addr[0] = 6'd50; read_Addr[1] = 6'd47; issue();
    alloc_En = 1'b1; alloc_Addr = 6'd0; read_Addr[0] = 6'd50; issue();
    read_Addr[0] = 6'd0; read_Addr[1] = 6'd47; issue();

    // Asynchronous reset with busy bits set: checked before the next edge
    alloc_En = 1'b1; alloc_Addr = 6'd5; issue();
    alloc_En = 1'b1; alloc_Addr = 6'd6; read_Addr[0] = 6'd5; issue();
    rst_n = 1'b0; read_Addr[0] = 6'd3; read_Addr[1] = 6'd6; issue();
    rst_n = 1'b1;
    read_Addr[0] = 6'd3; read_Addr[1] = 6'd9; issue();

    // Randomized traffic concentrated on a few registers to force clashes
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < WP; p++) begin
        write_En[p] = ($urandom_range(0, 2) != 0);
        write_Addr[p] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 15));
        write_Data[p] = $urandom;
      end
      alloc_En = ($urandom_range(0, 2) == 0);
      alloc_Addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 15));
      flush = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < RP; i++) begin
        read_Addr[i] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 15));
      end
      issue();
    end

    // Drain: give the monitor a bounded number of cycles
    for (int w = 0; w < 5 && q.size() > 0; w++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mwp_sb.md
Name: regfile_mwp_sb

Overview:
- Parametrised scalar integer register file, successor to the two-write-port file.
- Generalised to N write ports and M read ports.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard (set at issue, cleared at writeback, bulk-cleared on flush).
- Sits between issue/decode (read and allocate side) and the writeback stage(s) (write side) of the scalar pipeline.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 6, register address width.
- SIZE, 64, number of registers; must be <= 2**ADDR_WIDTH.
- READ_PORTS, 2, number of read ports.
- WRITE_PORTS, 2, number of write ports; higher index = higher priority.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- write_En  in  [WRITE_PORTS-1:0]  per-port write enable.
- write_Addr  in  [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]  per-port write address.
- write_Data  in  [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  per-port write data.
- alloc_En  in  1  mark alloc_Addr busy (new in-flight producer).
- alloc_Addr  in  ADDR_WIDTH  register to mark busy.
- flush  in  1  clear all busy bits.
- read_Addr  in  [READ_PORTS-1:0][ADDR_WIDTH-1:0]  per-port read address.
- data_Out  out  [READ_PORTS-1:0][DATA_WIDTH-1:0]  read data, bypassed.
- read_Ready  out  [READ_PORTS-1:0]  operand available (not busy, or being written this cycle).
- busy_Vec  out  SIZE  current busy bits (debug/stall logic).

Behaviour:
- Reset (async, rst_n=0): all registers = 0; all busy bits = 0. Result during reset: data_Out = 0, read_Ready = all 1, busy_Vec = 0. Reset mid-operation discards any pending allocations.
- Register 0 is read-only zero:
  - Writes to address 0 are ignored.
  - alloc_En to address 0 is ignored; busy[0] is always 0.
  - Reads of address 0 return 0 with read_Ready = 1.
- Addresses >= SIZE:
  - Writes and allocs to them are ignored.
  - Reads of them return 0 with read_Ready = 1.
- Write (registered, 1-cycle): on the rising edge, each enabled port with a non-zero in-range address updates its register.
  - Several ports hitting the same address: the highest-index port wins.
  - Different addresses: all ports commit in parallel.
- Read (combinational, 0-cycle, with bypass): for each read port, if any enabled write port targets the same non-zero address this cycle, data_Out = that port's write_Data. Priority is the highest index. Otherwise data_Out = stored value.
- Scoreboard (registered), next-state per register r, in priority order:
  1. flush=1: busy[r] <= 0 for all r. A same-cycle alloc_En is dropped.
  2. alloc_En && alloc_Addr==r: busy[r] <= 1. Allocation beats a same-cycle writeback to r (a new producer supersedes the old one).
  3. Any enabled write to r: busy[r] <= 0.
  4. Otherwise: hold.
- Writes always update data regardless of busy state and flush.
- read_Ready[i] = !busy[read_Addr[i]] || (any enabled write to read_Addr[i] this cycle). It is combinational from current busy bits and write inputs. It does not look ahead to a same-cycle alloc or flush.
- busy_Vec reflects registered state only (no bypass).
- No backpressure: every write and alloc presented is accepted in its cycle.

Test Plan:
- Reset, then read x5 and x0 on both ports -> data_Out = 0, read_Ready = 1, busy_Vec = 0.
- Cycle 1: write_En[0] x3 = 0xDEAD_BEEF. Same cycle, read x3 -> 0xDEADBEEF (bypass). Cycle 2, no write, read x3 -> 0xDEADBEEF (stored).
- Same cycle: port0 writes x7 = 0x11, port1 writes x7 = 0x22 -> bypass read returns 0x22; next cycle stored value is 0x22. Port0 writes x0 = 0x55 -> x0 reads 0.
- alloc x9 -> next cycle busy_Vec[9] = 1, read x9 gives read_Ready = 0. Then write x9 = 0x1234 -> same-cycle read_Ready = 1 with data 0x1234; next cycle busy[9] = 0.
- alloc x4 plus write x4 in the same cycle -> x4 data updated, busy[4] = 1 next cycle. alloc x4 plus flush in the same cycle -> busy_Vec = 0 next cycle.
- Allocate x1, x2, x10, then flush -> busy_Vec = 0, register data unchanged. Assert rst_n = 0 with busy bits set -> busy_Vec and registers cleared immediately, before the next edge.
